fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch stage of the 6-stage MIPS pipeline. Owns the PC and runs a req/ready handshake with instruction memory. Presents fetched words to IF/ID with a valid flag. Applies hazard-unit stalls and branch/jump redirects, and flags a stuck memory with a sticky error.

---
 rtl/fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ready
// handshake, feeds IF/ID, applies stalls/redirects and flags memory timeouts.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inscode,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        flush,
  output logic        fetch_err
);
  localparam int unsigned   CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);
  localparam logic [31:0]   STEP     = 32'(PC_STEP);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, ERR} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   skid;
  logic [CW-1:0] wait_cnt;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_next;
  logic        timeout;

  // branch is the older instruction, so it beats a same-cycle jump
  assign redirect = br_taken | jmp;
  assign target   = (br_taken ? br_target : jmp_target) & 32'hFFFF_FFFC;
  assign pc_next  = pc + STEP;
  assign timeout  = (wait_cnt == WAIT_MAX) && !imem_ready;

  // fetch sequencer; every output is a register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      skid       <= '0;
      wait_cnt   <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      if_inscode <= '0;
      if_pc      <= '0;
      if_valid   <= 1'b0;
      flush      <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          if (redirect) begin
            pc        <= target;
            imem_addr <= target;
            flush     <= 1'b1;
            if_valid  <= 1'b0;
          end else begin
            imem_addr <= pc;
          end
        end
        REQ: begin
          if (!imem_ready) begin
            if (timeout) begin
              state     <= ERR;
              fetch_err <= 1'b1;
              imem_req  <= 1'b0;
              if_valid  <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
              // issued request can't be withdrawn: drain it on redirect
              if (redirect) begin
                pc       <= target;
                flush    <= 1'b1;
                if_valid <= 1'b0;
                state    <= DRAIN;
              end else if (!stall) begin
                if_valid <= 1'b0;
              end
            end
          end else begin
            wait_cnt <= '0;
            if (redirect) begin
              pc        <= target;
              imem_addr <= target;
              flush     <= 1'b1;
              if_valid  <= 1'b0;
            end else if (stall) begin
              skid     <= imem_rdata;
              imem_req <= 1'b0;
              state    <= HOLD;
            end else begin
              if_inscode <= imem_rdata;
              if_pc      <= pc;
              if_valid   <= 1'b1;
              pc         <= pc_next;
              imem_addr  <= pc_next;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc        <= target;
            imem_addr <= target;
            imem_req  <= 1'b1;
            flush     <= 1'b1;
            if_valid  <= 1'b0;
            state     <= REQ;
          end else if (!stall) begin
            if_inscode <= skid;
            if_pc      <= pc;
            if_valid   <= 1'b1;
            pc         <= pc_next;
            imem_addr  <= pc_next;
            imem_req   <= 1'b1;
            state      <= REQ;
          end
        end
        DRAIN: begin
          if_valid <= 1'b0;
          if (!imem_ready) begin
            if (timeout) begin
              state     <= ERR;
              fetch_err <= 1'b1;
              imem_req  <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
              if (redirect) begin
                pc    <= target;
                flush <= 1'b1;
              end
            end
          end else begin
            // stale word is dropped; fetch the redirected pc next
            wait_cnt <= '0;
            state    <= REQ;
            if (redirect) begin
              pc        <= target;
              imem_addr <= target;
              flush     <= 1'b1;
            end else begin
              imem_addr <= pc;
            end
          end
        end
        ERR: begin
          imem_req <= 1'b0;
          if_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with constant
// expectations plus randomized traffic against a flag-based fetch model.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;

  logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, br_taken = 1'b0, jmp = 1'b0, imem_ready = 1'b0;
  logic [31:0] br_target = '0, jmp_target = '0, imem_rdata = '0;
  logic        imem_req, if_valid, flush, fetch_err;
  logic [31:0] imem_addr, if_inscode, if_pc;
  int n_chk = 0, n_fail = 0;

  fetch_ctrl #(.RESET_PC(RESET_PC), .PC_STEP(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_inscode(if_inscode),
    .if_pc(if_pc), .if_valid(if_valid), .flush(flush), .fetch_err(fetch_err));

  always #5 clk = ~clk;

  // reference model: outstanding request / parked words / discard flag
  logic [31:0] m_pc, m_addr, m_ins, m_ipc;
  logic        m_req, m_valid, m_flush, m_err, m_started, m_drop;
  int          m_wait;
  logic [31:0] m_skid[$];

  task automatic model_reset();
    m_pc = RESET_PC; m_addr = '0; m_ins = '0; m_ipc = '0;
    m_req = 0; m_valid = 0; m_flush = 0; m_err = 0; m_started = 0; m_drop = 0;
    m_wait = 0; m_skid.delete();
  endtask

  task automatic model_edge();
    logic redir;
    logic [31:0] tgt;
    redir = br_taken | jmp;
    tgt = (br_taken ? br_target : jmp_target) & ~32'h3;
    m_flush = 0;
    if (m_err) return;
    if (!m_started) begin
      m_started = 1; m_req = 1;
      if (redir) begin m_pc = tgt; m_flush = 1; m_valid = 0; end
      m_addr = m_pc;
    end else if (m_skid.size() != 0) begin
      if (redir) begin
        m_skid.delete(); m_pc = tgt; m_addr = tgt; m_req = 1; m_flush = 1; m_valid = 0;
      end else if (!stall) begin
        m_ins = m_skid.pop_front(); m_ipc = m_pc; m_valid = 1;
        m_pc = m_pc + 4; m_addr = m_pc; m_req = 1;
      end
    end else if (!imem_ready) begin
      if (m_wait == TIMEOUT - 1) begin
        m_err = 1; m_req = 0; m_valid = 0;
      end else begin
        m_wait++;
        if (redir) begin m_pc = tgt; m_flush = 1; m_valid = 0; m_drop = 1; end
        else if (m_drop || !stall) m_valid = 0;
      end
    end else begin
      m_wait = 0;
      if (redir) begin
        m_pc = tgt; m_addr = tgt; m_flush = 1; m_valid = 0; m_drop = 0;
      end else if (m_drop) begin
        m_drop = 0; m_addr = m_pc; m_valid = 0;
      end else if (stall) begin
        m_skid.push_back(imem_rdata); m_req = 0;
      end else begin
        m_ins = imem_rdata; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 4; m_addr = m_pc;
      end
    end
  endtask

  // apply one cycle of inputs, clock it, advance the model
  task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic r);
    stall = s; br_taken = b; br_target = bt; jmp = j; jmp_target = jt; imem_ready = r;
    imem_rdata = $urandom;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 0; stall = 0; br_taken = 0; jmp = 0; imem_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    #1;
    n_chk++;
    if ({imem_req, imem_addr, if_inscode, if_pc, if_valid, flush, fetch_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: req=%0b addr=%h ins=%h pc=%h v=%0b fl=%0b err=%0b required all zero",
               imem_req, imem_addr, if_inscode, if_pc, if_valid, flush, fetch_err);
    end
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 0;
    #1;
    n_chk++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_req: imem_req=%0b required 0", imem_req);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1)) || flush !== 1'b0) begin
        n_fail++; $display("FAIL stream_addr: req=%0b addr=%h fl=%0b required 1 %h 0",
                           imem_req, imem_addr, flush, 32'(4 * (k - 1)));
      end
      if (k >= 2) begin
        n_chk++;
        if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 2)) || if_inscode !== imem_rdata) begin
          n_fail++; $display("FAIL stream_ifid: v=%0b pc=%h ins=%h required 1 %h %h",
                             if_valid, if_pc, if_inscode, 32'(4 * (k - 2)), imem_rdata);
        end
      end
    end
  endtask

  task automatic test_wait();
    do_reset();
    repeat (3) drive(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin
        n_fail++; $display("FAIL wait_hold: req=%0b addr=%h v=%0b required 1 8 0", imem_req, imem_addr, if_valid);
      end
    end
    drive(0, 0, 0, 0, 0, 1);
    n_chk++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inscode !== imem_rdata || imem_addr !== 32'hc) begin
      n_fail++; $display("FAIL wait_done: v=%0b pc=%h ins=%h addr=%h required 1 8 %h c",
                         if_valid, if_pc, if_inscode, imem_addr, imem_rdata);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ins0, w;
    do_reset();
    repeat (4) drive(0, 0, 0, 0, 0, 1);
    ins0 = if_inscode;
    drive(1, 0, 0, 0, 0, 0);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hc || if_valid !== 1'b1 || if_pc !== 32'h8 || if_inscode !== ins0) begin
      n_fail++; $display("FAIL stall_keep_req: req=%0b addr=%h v=%0b pc=%h required 1 c 1 8", imem_req, imem_addr, if_valid, if_pc);
    end
    drive(1, 0, 0, 0, 0, 1);
    w = imem_rdata;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) drive(1, 0, 0, 0, 0, 1'($urandom));
      n_chk++;
      if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h8 || if_inscode !== ins0) begin
        n_fail++; $display("FAIL stall_hold: req=%0b v=%0b pc=%h ins=%h required 0 1 8 %h",
                           imem_req, if_valid, if_pc, if_inscode, ins0);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (if_valid !== 1'b1 || if_pc !== 32'hc || if_inscode !== w || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_fail++; $display("FAIL stall_release: v=%0b pc=%h ins=%h req=%0b addr=%h required 1 c %h 1 10",
                         if_valid, if_pc, if_inscode, imem_req, imem_addr, w);
    end
    drive(0, 0, 0, 0, 0, 1);
    n_chk++;
    if (if_pc !== 32'h10 || if_valid !== 1'b1 || imem_addr !== 32'h14) begin
      n_fail++; $display("FAIL stall_resume: pc=%h v=%0b addr=%h required 10 1 14", if_pc, if_valid, imem_addr);
    end
  endtask

  task automatic test_redirect_ready();
    do_reset();
    repeat (6) drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 32'h107, 1, 32'h200, 1);
    n_chk++;
    if (flush !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h104 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL redir_ready: fl=%0b v=%0b addr=%h req=%0b required 1 0 104 1", flush, if_valid, imem_addr, imem_req);
    end
    drive(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (flush !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h104) begin
      n_fail++; $display("FAIL redir_bubble: fl=%0b v=%0b addr=%h required 0 0 104", flush, if_valid, imem_addr);
    end
    drive(0, 0, 0, 0, 0, 1);
    n_chk++;
    if (if_valid !== 1'b1 || if_pc !== 32'h104 || if_inscode !== imem_rdata || imem_addr !== 32'h108) begin
      n_fail++; $display("FAIL redir_target: v=%0b pc=%h addr=%h required 1 104 108", if_valid, if_pc, imem_addr);
    end
  endtask

  task automatic test_drain();
    int flushes;
    do_reset();
    repeat (7) drive(0, 0, 0, 0, 0, 1);
    flushes = 0;
    drive(0, 0, 0, 1, 32'h40, 0);
    flushes += int'(flush);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h18 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_hold: req=%0b addr=%h v=%0b required 1 18 0", imem_req, imem_addr, if_valid);
    end
    drive(0, 0, 0, 0, 0, 0);
    flushes += int'(flush);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h18) begin
      n_fail++; $display("FAIL drain_wait: req=%0b addr=%h required 1 18", imem_req, imem_addr);
    end
    drive(0, 0, 0, 0, 0, 1);
    flushes += int'(flush);
    n_chk++;
    if (imem_addr !== 32'h40 || if_valid !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL drain_discard: addr=%h v=%0b req=%0b required 40 0 1", imem_addr, if_valid, imem_req);
    end
    drive(0, 0, 0, 0, 0, 1);
    flushes += int'(flush);
    n_chk++;
    if (if_pc !== 32'h40 || if_valid !== 1'b1 || flushes != 1) begin
      n_fail++; $display("FAIL drain_new: pc=%h v=%0b flushes=%0d required 40 1 1", if_pc, if_valid, flushes);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      n_chk++;
      if (fetch_err !== (k == TIMEOUT)) begin
        n_fail++; $display("FAIL timeout_edge: wait=%0d err=%0b required %0b", k, fetch_err, k == TIMEOUT);
      end
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, 1);
      n_chk++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0 || flush !== 1'b0) begin
        n_fail++; $display("FAIL err_sticky: err=%0b req=%0b v=%0b fl=%0b required 1 0 0 0", fetch_err, imem_req, if_valid, flush);
      end
    end
    rst = 0;
    #1;
    n_chk++;
    if (fetch_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: err=%0b required 0", fetch_err);
    end
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL err_restart: req=%0b addr=%h required 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom,
            $urandom_range(15) == 0, $urandom, $urandom_range(9) < 7);
      n_chk++;
      if ({imem_req, imem_addr, if_inscode, if_pc, if_valid, flush, fetch_err} !==
          {m_req, m_addr, m_ins, m_ipc, m_valid, m_flush, m_err}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: req=%0b addr=%h ins=%h pc=%h v=%0b fl=%0b err=%0b required %0b %h %h %h %0b %0b %0b",
                 k, imem_req, imem_addr, if_inscode, if_pc, if_valid, flush, fetch_err,
                 m_req, m_addr, m_ins, m_ipc, m_valid, m_flush, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_redirect_ready();
    test_drain();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
